// File: rtl/gardner_timing_nco_pkg.sv
// Shared types and period constants for the Gardner timing NCO.
package gardner_timing_nco_pkg;

  // Symbol-timing FSM: first the mid-symbol point, then the symbol point.
  typedef enum logic {
    S_MID = 1'b0,
    S_SYM = 1'b1
  } nco_state_t;

  // Nominal symbol period in fractional phase units.
  function automatic int nom_period(input int sps_log2, input int frac);
    return 1 << (sps_log2 + frac);
  endfunction

  // Shortest allowed period: nominal minus a quarter.
  function automatic int min_period(input int sps_log2, input int frac);
    int n;
    n = nom_period(sps_log2, frac);
    return n - n / 4;
  endfunction

  // Longest allowed period: nominal plus a quarter.
  function automatic int max_period(input int sps_log2, input int frac);
    int n;
    n = nom_period(sps_log2, frac);
    return n + n / 4;
  endfunction

endpackage

// File: rtl/gardner_timing_nco_period_limiter.sv
// Scales the negated Gardner error and clamps the resulting symbol period.
module timing_period_limiter #(
  parameter int ERR_W = 16,
  parameter int PW    = 15,
  parameter int NOM   = 8192,
  parameter int PMIN  = 6144,
  parameter int PMAX  = 10240
) (
  input  logic signed [ERR_W-1:0] error_n,
  input  logic        [3:0]       shift,
  output logic        [PW-1:0]    period_next,
  output logic                    clamped
);

  // Two guard bits above the wider operand so the sum can never wrap.
  localparam int SW = ((ERR_W > PW) ? ERR_W : PW) + 2;
  localparam logic signed [SW-1:0] NOM_S  = SW'(NOM);
  localparam logic signed [SW-1:0] PMIN_S = SW'(PMIN);
  localparam logic signed [SW-1:0] PMAX_S = SW'(PMAX);

  logic signed [SW-1:0] err_ext;
  logic signed [SW-1:0] scaled;
  logic signed [SW-1:0] sum;

  // Sign-extend, arithmetic shift, add to nominal, then saturate.
  always_comb begin
    err_ext     = {{(SW-ERR_W){error_n[ERR_W-1]}}, error_n};
    scaled      = err_ext >>> shift;
    sum         = NOM_S + scaled;
    period_next = PW'(sum);
    clamped     = 1'b0;
    if (sum < PMIN_S) begin
      period_next = PW'(PMIN);
      clamped     = 1'b1;
    end else if (sum > PMAX_S) begin
      period_next = PW'(PMAX);
      clamped     = 1'b1;
    end
  end

endmodule

// File: rtl/gardner_timing_nco.sv
// Gardner timing NCO: tracks symbol phase, picks mid-symbol and symbol-point
// samples, and adjusts the symbol period from the detector's error.
//
// Interface semantics: there is no back-pressure. en marks a valid input
// sample and is consumed on the same edge; sym_valid / mid_valid are
// single-cycle strobes qualifying the registered I/Q outputs, which hold
// their value between strobes. error_valid qualifies error_n and
// GARDNER_SHIFT, which are ignored on other cycles.
module gardner_timing_nco
  import gardner_timing_nco_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int ERR_W    = 16,
  parameter int SPS_LOG2 = 5,
  parameter int FRAC     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic        [3:0]             GARDNER_SHIFT,
  input  logic signed [WIDTH-1:0]       I_in,
  input  logic signed [WIDTH-1:0]       Q_in,
  input  logic signed [ERR_W-1:0]       error_n,
  input  logic                          error_valid,
  output logic signed [WIDTH-1:0]       I_sym,
  output logic signed [WIDTH-1:0]       Q_sym,
  output logic                          sym_valid,
  output logic signed [WIDTH-1:0]       I_mid,
  output logic signed [WIDTH-1:0]       Q_mid,
  output logic                          mid_valid,
  output logic                          period_clamped,
  output nco_state_t                    dbg_state,
  output logic [SPS_LOG2+FRAC+1:0]      dbg_phase,
  output logic [SPS_LOG2+FRAC+1:0]      dbg_period
);

  localparam int PW   = SPS_LOG2 + FRAC + 2;
  localparam int NOM  = nom_period(SPS_LOG2, FRAC);
  localparam int PMIN = min_period(SPS_LOG2, FRAC);
  localparam int PMAX = max_period(SPS_LOG2, FRAC);
  localparam logic [PW-1:0] ONE   = PW'(1 << FRAC);
  localparam logic [PW-1:0] NOM_P = PW'(NOM);

  nco_state_t    state;
  logic [PW-1:0] phase;
  logic [PW-1:0] period;
  logic [PW-1:0] p;
  logic [PW-1:0] half;
  logic [PW-1:0] period_next;
  logic          clamped;

  timing_period_limiter #(
    .ERR_W (ERR_W),
    .PW    (PW),
    .NOM   (NOM),
    .PMIN  (PMIN),
    .PMAX  (PMAX)
  ) u_limiter (
    .error_n     (error_n),
    .shift       (GARDNER_SHIFT),
    .period_next (period_next),
    .clamped     (clamped)
  );

  // Candidate phase for this sample and the mid-symbol threshold.
  always_comb begin
    p    = phase + ONE;
    half = period >> 1;
  end

  // Phase accumulator, sample capture FSM and period register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_MID;
      phase          <= '0;
      period         <= NOM_P;
      period_clamped <= 1'b0;
      sym_valid      <= 1'b0;
      mid_valid      <= 1'b0;
      I_sym          <= '0;
      Q_sym          <= '0;
      I_mid          <= '0;
      Q_mid          <= '0;
    end else begin
      sym_valid <= 1'b0;
      mid_valid <= 1'b0;
      if (en) begin
        case (state)
          S_MID: begin
            phase <= p;
            if (p >= half) begin
              I_mid     <= I_in;
              Q_mid     <= Q_in;
              mid_valid <= 1'b1;
              state     <= S_SYM;
            end
          end
          S_SYM: begin
            if (p >= period) begin
              // Uses the period in force before any same-cycle update.
              I_sym     <= I_in;
              Q_sym     <= Q_in;
              sym_valid <= 1'b1;
              phase     <= p - period;
              state     <= S_MID;
            end else begin
              phase <= p;
            end
          end
          default: state <= S_MID;
        endcase
      end
      if (error_valid) begin
        period         <= period_next;
        period_clamped <= clamped;
      end
    end
  end

  // Internal state exposed for observation.
  always_comb begin
    dbg_state  = state;
    dbg_phase  = phase;
    dbg_period = period;
  end

endmodule
